// File: rtl/npu_operand_fetch_pkg.sv
// rtl/npu_operand_fetch_pkg.sv - shared select code, FSM states and widths for the NPU operand fetcher
package npu_operand_fetch_pkg;

  localparam logic SEL_NPU_ALU = 1'b1;
  localparam int   ADDR_W      = 5;
  localparam int   LANE_W      = 8;

  typedef enum logic [1:0] {
    FETCH_IDLE,
    FETCH_RUN,
    FETCH_DRAIN,
    FETCH_DONE
  } fetch_state_e;

endpackage

// File: rtl/npu_operand_buf.sv
// rtl/npu_operand_buf.sv - NUM_OPS x 8-bit operand lane register with clear and indexed write
module npu_operand_buf
  import npu_operand_fetch_pkg::*;
#(
  parameter int NUM_OPS = 4,
  parameter int IDX_W   = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic                      wr_en,
  input  logic [IDX_W-1:0]          wr_idx,
  input  logic [LANE_W-1:0]         wr_data,
  output logic [NUM_OPS*LANE_W-1:0] lanes
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      lanes <= '0;
    end else if (wr_en) begin
      for (int k = 0; k < NUM_OPS; k++) begin
        if (wr_idx == IDX_W'(k)) begin
          lanes[k*LANE_W +: LANE_W] <= wr_data;
        end
      end
    end
  end

endmodule

// File: rtl/npu_operand_fetch.sv
// rtl/npu_operand_fetch.sv - burst-fetches register-file operands for the NPU ALU and muxes the shared read port
module npu_operand_fetch
  import npu_operand_fetch_pkg::*;
#(
  parameter int NUM_OPS = 4,
  parameter int CNT_W   = $clog2(NUM_OPS + 1)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      npu_alu_sel_i,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic [ADDR_W-1:0]         req_base_addr_i,
  input  logic [CNT_W-1:0]          req_count_i,
  input  logic                      cpu_rd_en_i,
  input  logic [ADDR_W-1:0]         cpu_rd_addr_i,
  output logic                      rd_reg_en_o,
  output logic [ADDR_W-1:0]         rd_reg_addr_o,
  input  logic [LANE_W-1:0]         rd_reg_data_i,
  output logic                      ops_valid_o,
  input  logic                      ops_ready_i,
  output logic [NUM_OPS*LANE_W-1:0] ops_data_o,
  output logic                      busy_o
);

  fetch_state_e      state, state_next;
  logic [ADDR_W-1:0] base;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_clamped;
  logic [CNT_W-1:0]  issue_idx;
  logic [CNT_W-1:0]  capture_idx;
  logic              pending;
  logic              npu_sel;
  logic              issue;
  logic              last_issue;
  logic              capture;
  logic              clr;

  assign npu_sel       = (npu_alu_sel_i == SEL_NPU_ALU);
  assign issue         = (state == FETCH_RUN) && npu_sel;
  assign last_issue    = issue && (issue_idx == count - CNT_W'(1));
  // Returning data is captured even if the CPU has since taken the port.
  assign capture       = pending && ((state == FETCH_RUN) || (state == FETCH_DRAIN));
  assign clr           = (state == FETCH_IDLE) && req_valid_i;
  assign count_clamped = ((req_count_i == '0) || (req_count_i > CNT_W'(NUM_OPS)))
                         ? CNT_W'(NUM_OPS) : req_count_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= FETCH_IDLE;
      base        <= '0;
      count       <= '0;
      issue_idx   <= '0;
      capture_idx <= '0;
      pending     <= 1'b0;
    end else begin
      state   <= state_next;
      pending <= issue;
      if (clr) begin
        base        <= req_base_addr_i;
        count       <= count_clamped;
        issue_idx   <= '0;
        capture_idx <= '0;
      end else begin
        if (issue)   issue_idx   <= issue_idx + CNT_W'(1);
        if (capture) capture_idx <= capture_idx + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_next  = state;
    req_ready_o = 1'b0;
    ops_valid_o = 1'b0;
    busy_o      = 1'b1;
    case (state)
      FETCH_IDLE: begin
        req_ready_o = 1'b1;
        busy_o      = 1'b0;
        if (req_valid_i) state_next = FETCH_RUN;
      end
      FETCH_RUN: begin
        if (last_issue) state_next = FETCH_DRAIN;
      end
      FETCH_DRAIN: begin
        state_next = FETCH_DONE;
      end
      FETCH_DONE: begin
        ops_valid_o = 1'b1;
        if (ops_ready_i) state_next = FETCH_IDLE;
      end
      default: state_next = FETCH_IDLE;
    endcase
  end

  always_comb begin
    rd_reg_en_o   = 1'b0;
    rd_reg_addr_o = '0;
    if (!npu_sel) begin
      rd_reg_en_o   = cpu_rd_en_i;
      rd_reg_addr_o = cpu_rd_addr_i;
    end else if (issue) begin
      rd_reg_en_o   = 1'b1;
      rd_reg_addr_o = base + ADDR_W'(issue_idx);
    end
  end

  npu_operand_buf #(
    .NUM_OPS(NUM_OPS),
    .IDX_W  (CNT_W)
  ) u_buf (
    .clk    (clk_i),
    .rst    (rst_i),
    .clr    (clr),
    .wr_en  (capture),
    .wr_idx (capture_idx),
    .wr_data(rd_reg_data_i),
    .lanes  (ops_data_o)
  );

endmodule

// File: tb/tb_npu_operand_fetch.sv
// tb/tb_npu_operand_fetch.sv - scoreboard bench for npu_operand_fetch with directed bursts
module tb_npu_operand_fetch;
  localparam int NUM_OPS = 4;
  localparam int CNT_W   = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             sel;
  logic             req_valid;
  logic             req_ready;
  logic [4:0]       req_base;
  logic [CNT_W-1:0] req_count;
  logic             cpu_rd_en;
  logic [4:0]       cpu_rd_addr;
  logic             rd_en;
  logic [4:0]       rd_addr;
  logic [7:0]       rd_data;
  logic             ops_valid;
  logic             ops_ready;
  logic [31:0]      ops_data;
  logic             busy;

  npu_operand_fetch #(.NUM_OPS(NUM_OPS), .CNT_W(CNT_W)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .npu_alu_sel_i  (sel),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_base_addr_i(req_base),
    .req_count_i    (req_count),
    .cpu_rd_en_i    (cpu_rd_en),
    .cpu_rd_addr_i  (cpu_rd_addr),
    .rd_reg_en_o    (rd_en),
    .rd_reg_addr_o  (rd_addr),
    .rd_reg_data_i  (rd_data),
    .ops_valid_o    (ops_valid),
    .ops_ready_i    (ops_ready),
    .ops_data_o     (ops_data),
    .busy_o         (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] regs [32];
  always @(posedge clk) if (rd_en) rd_data <= regs[rd_addr];

  typedef struct {
    logic [31:0] data;
    int          vcyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input logic [31:0] d, input int c);
    exp_t e;
    e.data = d;
    e.vcyc = c;
    exp_q.push_back(e);
  endtask

  logic        prev_valid = 1'b0;
  logic        prev_ready = 1'b0;
  logic [31:0] cur_exp    = '0;

  always @(negedge clk) begin
    if (ops_valid && !prev_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 32'd1, 32'd0);
      end else begin
        mon_e   = exp_q.pop_front();
        cur_exp = mon_e.data;
        check("ops_data", ops_data, mon_e.data);
        check("valid_cycle", cyc, mon_e.vcyc);
      end
    end
    if (ops_valid && prev_valid && !prev_ready) check("hold_data", ops_data, cur_exp);
    prev_valid = ops_valid;
    prev_ready = ops_ready;
  end

  task automatic do_req(input logic [4:0] b, input logic [CNT_W-1:0] c, output int t0);
    req_valid = 1'b1;
    req_base  = b;
    req_count = c;
    #1 check("req_ready", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    t0 = cyc;
  endtask

  task automatic expect_port(input string name, input logic en, input logic [4:0] addr);
    @(negedge clk);
    check({name, "_en"}, rd_en, en);
    if (en) check({name, "_addr"}, rd_addr, addr);
    @(posedge clk); #1;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    @(negedge clk);
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({name, "_idle"}, busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t0;
    int n;
    rst = 1'b1; sel = 1'b1; req_valid = 1'b0; req_base = '0; req_count = '0;
    cpu_rd_en = 1'b0; cpu_rd_addr = '0; ops_ready = 1'b1;
    for (int i = 0; i < 32; i++) regs[i] = 8'hA0 + i[7:0];
    regs[3] = 8'h11; regs[4] = 8'h22; regs[5] = 8'h33; regs[6] = 8'h44;
    regs[30] = 8'h5A; regs[31] = 8'h6B; regs[0] = 8'h7C; regs[9] = 8'h99;

    // reset state
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_req_ready", req_ready, 1);
    check("rst_ops_valid", ops_valid, 0);
    check("rst_ops_data", ops_data, 0);
    check("rst_busy", busy, 0);
    check("rst_rd_en_npu", rd_en, 0);
    sel = 1'b0; cpu_rd_en = 1'b1; cpu_rd_addr = 5'd7;
    #1 check("rst_rd_en_cpu", rd_en, 1);
    check("rst_rd_addr_cpu", rd_addr, 7);
    cpu_rd_en = 1'b0;
    #1 check("rst_rd_en_cpu_off", rd_en, 0);
    sel = 1'b1;
    #1;

    // basic burst
    do_req(5'd3, 3'd4, t0);
    push_exp(32'h44332211, t0 + 5);
    for (int i = 0; i < 4; i++) expect_port("basic", 1'b1, 5'(3 + i));
    expect_port("basic_drain", 1'b0, 5'd0);
    wait_idle("basic");

    // address wrap
    do_req(5'd30, 3'd3, t0);
    push_exp(32'h007C6B5A, t0 + 4);
    expect_port("wrap", 1'b1, 5'd30);
    expect_port("wrap", 1'b1, 5'd31);
    expect_port("wrap", 1'b1, 5'd0);
    expect_port("wrap_drain", 1'b0, 5'd0);
    wait_idle("wrap");

    // CPU stall after the second issue
    do_req(5'd3, 3'd4, t0);
    push_exp(32'h44332211, t0 + 7);
    expect_port("stall", 1'b1, 5'd3);
    expect_port("stall", 1'b1, 5'd4);
    sel = 1'b0; cpu_rd_en = 1'b1; cpu_rd_addr = 5'd9;
    expect_port("stall_cpu", 1'b1, 5'd9);
    expect_port("stall_cpu", 1'b1, 5'd9);
    sel = 1'b1; cpu_rd_en = 1'b0;
    expect_port("stall", 1'b1, 5'd5);
    expect_port("stall", 1'b1, 5'd6);
    expect_port("stall_drain", 1'b0, 5'd0);
    wait_idle("stall");

    // backpressure in DONE, new request held off until after the handshake
    ops_ready = 1'b0;
    do_req(5'd5, 3'd2, t0);
    push_exp(32'h00004433, t0 + 3);
    n = 0;
    @(negedge clk);
    while (!ops_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("bp_valid", ops_valid, 1);
    @(posedge clk); #1;
    req_valid = 1'b1; req_base = 5'd10; req_count = 3'd1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_req_ready", req_ready, 0);
      check("bp_ops_valid", ops_valid, 1);
      check("bp_rd_en", rd_en, 0);
      @(posedge clk); #1;
    end
    ops_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_after_hs_busy", busy, 0);
    check("bp_after_hs_ready", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    t0 = cyc;
    push_exp(32'h000000AA, t0 + 2);
    expect_port("bp_next", 1'b1, 5'd10);
    wait_idle("bp_next");

    // count 0 clamps to NUM_OPS
    do_req(5'd12, 3'd0, t0);
    push_exp(32'hAFAEADAC, t0 + 5);
    for (int i = 0; i < 4; i++) expect_port("clamp", 1'b1, 5'(12 + i));
    expect_port("clamp_drain", 1'b0, 5'd0);
    wait_idle("clamp");

    // reset in the cycle after the second issue
    do_req(5'd20, 3'd4, t0);
    expect_port("rstb", 1'b1, 5'd20);
    expect_port("rstb", 1'b1, 5'd21);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rstb_busy", busy, 0);
      check("rstb_ops_valid", ops_valid, 0);
      check("rstb_ops_data", ops_data, 0);
      check("rstb_rd_en", rd_en, 0);
      @(posedge clk); #1;
    end

    check("exp_queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
